// File: rtl/commu_m_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : commu_m_regbank
//  Purpose  : fx-bus register bank for one functional module. Decodes writes
//             and reads addressed to mod_id and provides config registers
//             with write strobes, sticky read-to-clear status registers, a
//             key-protected write lock with a saturating rejected-write
//             counter, and ID / version readback.
//  Ports    : clk_sys, rst         - clock, synchronous active-high reset
//             mod_id               - module id, matched against addr[13:8]
//             fx_waddr/fx_wr/fx_data - write channel
//             fx_raddr/fx_rd/fx_q  - read channel, fx_q registered, 1 cycle
//             cfg_q / cfg_wstb     - config contents and write pulses
//             stat_evt             - status event bits, sampled every cycle
//             cfg_locked           - current lock state
//  Revision : 1.0 - initial release
// ============================================================================
module commu_m_regbank #(
   parameter int                 DW        = 8,
   parameter int                 NREG      = 8,
   parameter int                 NSTAT     = 4,
   parameter int                 CFG_BASE  = 8'h80,
   parameter int                 STAT_BASE = 8'h40,
   parameter logic [NREG*DW-1:0] RST_VAL   = '0,
   parameter bit                 LOCK_EN   = 1'b1,
   parameter logic [7:0]         KEY       = 8'hA5,
   parameter logic [7:0]         VERSION   = 8'h02
) (
   input  logic                  clk_sys,
   input  logic                  rst,
   input  logic [5:0]            mod_id,
   input  logic [15:0]           fx_waddr,
   input  logic                  fx_wr,
   input  logic [DW-1:0]         fx_data,
   input  logic [15:0]           fx_raddr,
   input  logic                  fx_rd,
   output logic [DW-1:0]         fx_q,
   output logic [NREG*DW-1:0]    cfg_q,
   output logic [NREG-1:0]       cfg_wstb,
   input  logic [NSTAT*DW-1:0]   stat_evt,
   output logic                  cfg_locked
);

   localparam int         NS          = (NSTAT > 0) ? NSTAT : 1;
   localparam logic [7:0] C_ADDR_ID   = 8'h00;
   localparam logic [7:0] C_ADDR_VER  = 8'h01;
   localparam logic [7:0] C_ADDR_ERR  = 8'hFE;
   localparam logic [7:0] C_ADDR_LOCK = 8'hFF;

   // Elaboration-time sanity check of the address map and sizes.
   generate
      if ((DW < 8) || (DW > 32) || (NREG < 1) || (NREG > 64) ||
          (NSTAT < 0) || (NSTAT > 16) ||
          (CFG_BASE < 2) || (CFG_BASE + NREG - 1 > 253) ||
          ((NSTAT > 0) && ((STAT_BASE < 2) || (STAT_BASE + NSTAT - 1 > 253) ||
                           !((STAT_BASE + NSTAT <= CFG_BASE) ||
                             (CFG_BASE + NREG <= STAT_BASE))))) begin : g_bad_map
         $error("commu_m_regbank: illegal parameter set or overlapping address map");
      end
   endgenerate

   // ---------------------------------------------------------------- decode
   logic       w_now_wr, w_now_rd;
   logic [7:0] w_wa, w_ra;
   logic       w_lock_wr, w_err_wr;
   logic       w_unused;

   assign w_now_wr  = fx_wr & (fx_waddr[13:8] == mod_id);
   assign w_now_rd  = fx_rd & (fx_raddr[13:8] == mod_id);
   assign w_wa      = fx_waddr[7:0];
   assign w_ra      = fx_raddr[7:0];
   assign w_lock_wr = w_now_wr & (w_wa == C_ADDR_LOCK);
   assign w_err_wr  = w_now_wr & (w_wa == C_ADDR_ERR);
   // Upper address bits carry no meaning for this bank.
   assign w_unused  = &{1'b0, fx_waddr[15:14], fx_raddr[15:14]};

   // ------------------------------------------------------------------ lock
   logic r_locked;

   generate
      if (LOCK_EN) begin : g_lock
         always_ff @(posedge clk_sys) begin
            if (rst)
               r_locked <= 1'b1;
            else if (w_lock_wr)
               r_locked <= (fx_data[7:0] != KEY);
         end
      end else begin : g_nolock
         assign r_locked = 1'b0;
      end
   endgenerate

   assign cfg_locked = r_locked;

   // ------------------------------------------------------- config registers
   logic [DW-1:0]   r_cfg [NREG];
   logic [NREG-1:0] w_cfg_hit;
   logic [NREG-1:0] r_wstb;

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_cfg
         assign w_cfg_hit[gi] = w_now_wr & (int'(w_wa) == CFG_BASE + gi);

         always_ff @(posedge clk_sys) begin
            if (rst) begin
               r_cfg[gi]  <= RST_VAL[gi*DW +: DW];
               r_wstb[gi] <= 1'b0;
            end else begin
               // Strobe is registered so it lines up with the new cfg_q value.
               r_wstb[gi] <= w_cfg_hit[gi] & ~r_locked;
               if (w_cfg_hit[gi] && !r_locked)
                  r_cfg[gi] <= fx_data;
            end
         end

         assign cfg_q[gi*DW +: DW] = r_cfg[gi];
      end
   endgenerate

   assign cfg_wstb = r_wstb;

   // ----------------------------------------------- rejected-write counter
   logic [7:0] r_errcnt;

   always_ff @(posedge clk_sys) begin
      if (rst)
         r_errcnt <= 8'h00;
      else if (w_err_wr)
         r_errcnt <= 8'h00;
      else if ((|w_cfg_hit) && r_locked && (r_errcnt != 8'hFF))
         r_errcnt <= r_errcnt + 8'h01;
   end

   // ------------------------------------------------------ status registers
   logic [DW-1:0] r_stat [NS];

   generate
      if (NSTAT > 0) begin : g_stat_on
         for (genvar gs = 0; gs < NSTAT; gs++) begin : g_stat
            logic w_clr;
            assign w_clr = w_now_rd & (int'(w_ra) == STAT_BASE + gs);

            // On the clearing read the new events are loaded instead of
            // OR-ed, so nothing arriving in that cycle is dropped.
            always_ff @(posedge clk_sys) begin
               if (rst)
                  r_stat[gs] <= '0;
               else if (w_clr)
                  r_stat[gs] <= stat_evt[gs*DW +: DW];
               else
                  r_stat[gs] <= r_stat[gs] | stat_evt[gs*DW +: DW];
            end
         end
      end else begin : g_stat_off
         assign r_stat[0] = '0;
      end
   endgenerate

   // --------------------------------------------------------------- readback
   logic [DW-1:0] w_rdata;

   always_comb begin
      w_rdata = '0;
      if (w_ra == C_ADDR_ID)
         w_rdata[5:0] = mod_id;
      else if (w_ra == C_ADDR_VER)
         w_rdata[7:0] = VERSION;
      else if (w_ra == C_ADDR_ERR)
         w_rdata[7:0] = r_errcnt;
      else if (w_ra == C_ADDR_LOCK)
         w_rdata[0] = r_locked;
      for (int i = 0; i < NREG; i++)
         if (int'(w_ra) == CFG_BASE + i)
            w_rdata = r_cfg[i];
      for (int i = 0; i < NSTAT; i++)
         if (int'(w_ra) == STAT_BASE + i)
            w_rdata = r_stat[i];
   end

   // Read data is zero whenever the previous cycle carried no accepted read.
   always_ff @(posedge clk_sys) begin
      if (rst)
         fx_q <= '0;
      else
         fx_q <= w_now_rd ? w_rdata : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_commu_m_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_commu_m_regbank
//  Purpose  : directed self-checking bench for commu_m_regbank; expected read
//             data is queued when a read is issued and checked one cycle
//             later by a monitor, other outputs are checked inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_commu_m_regbank;

   localparam int          DW      = 8;
   localparam int          NREG    = 8;
   localparam int          NSTAT   = 4;
   localparam logic [63:0] RST_VAL = 64'h8877_6655_4433_2211;

   logic                clk_sys = 1'b0;
   logic                rst     = 1'b1;
   logic [5:0]          mod_id  = 6'h05;
   logic [15:0]         fx_waddr = '0;
   logic                fx_wr    = 1'b0;
   logic [DW-1:0]       fx_data  = '0;
   logic [15:0]         fx_raddr = '0;
   logic                fx_rd    = 1'b0;
   logic [DW-1:0]       fx_q;
   logic [NREG*DW-1:0]  cfg_q;
   logic [NREG-1:0]     cfg_wstb;
   logic [NSTAT*DW-1:0] stat_evt = '0;
   logic                cfg_locked;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] sb_exp [$];
   string         sb_tag [$];

   always #5 clk_sys = ~clk_sys;

   commu_m_regbank #(
      .DW(DW), .NREG(NREG), .NSTAT(NSTAT),
      .CFG_BASE(8'h80), .STAT_BASE(8'h40), .RST_VAL(RST_VAL),
      .LOCK_EN(1'b1), .KEY(8'hA5), .VERSION(8'h02)
   ) dut (
      .clk_sys(clk_sys), .rst(rst), .mod_id(mod_id),
      .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
      .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q),
      .cfg_q(cfg_q), .cfg_wstb(cfg_wstb), .stat_evt(stat_evt),
      .cfg_locked(cfg_locked)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Issue one read cycle; the expected data is queued for the monitor.
   task automatic rd(input logic [15:0] addr, input logic [DW-1:0] exp, input string tag);
      fx_raddr = addr;
      fx_rd    = 1'b1;
      sb_exp.push_back(exp);
      sb_tag.push_back(tag);
      tick();
      fx_rd    = 1'b0;
   endtask

   task automatic wr(input logic [15:0] addr, input logic [DW-1:0] data);
      fx_waddr = addr;
      fx_data  = data;
      fx_wr    = 1'b1;
      tick();
      fx_wr    = 1'b0;
   endtask

   // Monitor: after every edge fx_q must equal the queued value if a read was
   // issued at that edge, else zero.
   logic mon_rd;
   always @(posedge clk_sys) begin
      mon_rd = fx_rd;
      #1;
      if (mon_rd) begin
         if (sb_exp.size() == 0) begin
            chk("sb_underflow", 64'd0, 64'd1);
         end else begin
            chk(sb_tag.pop_front(), {56'd0, fx_q}, {56'd0, sb_exp.pop_front()});
         end
      end else begin
         chk("fx_q_idle", {56'd0, fx_q}, 64'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk("rst_cfg_q", cfg_q, RST_VAL);
      chk("rst_locked", {63'd0, cfg_locked}, 64'd1);
      chk("rst_wstb", {56'd0, cfg_wstb}, 64'd0);

      rd(16'h0500, 8'h05, "rd_id");
      rd(16'h0501, 8'h02, "rd_version");

      // Locked write is rejected and counted.
      wr(16'h0580, 8'h3C);
      chk("locked_cfg0", {56'd0, cfg_q[7:0]}, 64'h11);
      chk("locked_wstb", {56'd0, cfg_wstb}, 64'd0);
      rd(16'h05FE, 8'h01, "errcnt_1");

      // Unlock and write.
      wr(16'h05FF, 8'hA5);
      rd(16'h05FF, 8'h00, "lock_rd_unlocked");
      wr(16'h0580, 8'h3C);
      chk("unl_cfg0", {56'd0, cfg_q[7:0]}, 64'h3C);
      chk("unl_wstb", {56'd0, cfg_wstb}, 64'h01);
      tick();
      chk("wstb_one_cycle", {56'd0, cfg_wstb}, 64'd0);

      // Same-cycle write and read of cfg1 returns the old value.
      fx_waddr = 16'h0581; fx_data = 8'h5A; fx_wr = 1'b1;
      rd(16'h0581, 8'h22, "rw_same_old");
      fx_wr = 1'b0;
      chk("rw_wstb", {56'd0, cfg_wstb}, 64'h02);
      rd(16'h0581, 8'h5A, "rw_same_new");

      // Other module's traffic ignored; upper address bits ignored.
      wr(16'h0680, 8'h11);
      chk("foreign_wstb", {56'd0, cfg_wstb}, 64'd0);
      chk("foreign_cfg0", {56'd0, cfg_q[7:0]}, 64'h3C);
      rd(16'h05FE, 8'h01, "errcnt_foreign");
      rd(16'h0680, 8'h00, "rd_foreign");
      rd(16'hC580, 8'h3C, "rd_upper_bits");
      rd(16'h0510, 8'h00, "rd_unmapped");

      // Sticky status with event coinciding with the clearing read.
      stat_evt = 32'h0000_0001;
      tick();
      stat_evt = 32'h0000_0002;
      rd(16'h0540, 8'h01, "stat_rd1");
      stat_evt = '0;
      rd(16'h0540, 8'h02, "stat_rd2");
      rd(16'h0540, 8'h00, "stat_rd3");

      // Read of LOCK concurrent with a locking write sees the old state.
      fx_waddr = 16'h05FF; fx_data = 8'h00; fx_wr = 1'b1;
      rd(16'h05FF, 8'h00, "lock_rd_old");
      fx_wr = 1'b0;
      rd(16'h05FF, 8'h01, "lock_rd_new");
      chk("locked_out", {63'd0, cfg_locked}, 64'd1);

      // Saturation of the rejected-write counter, then clear.
      for (int i = 0; i < 300; i++) wr(16'h0581, 8'hEE);
      chk("sat_cfg1", {56'd0, cfg_q[15:8]}, 64'h5A);
      rd(16'h05FE, 8'hFF, "errcnt_sat");
      wr(16'h05FE, 8'h37);
      rd(16'h05FE, 8'h00, "errcnt_clr");

      // Mid-operation reset.
      wr(16'h05FF, 8'hA5);
      wr(16'h0582, 8'h77);
      chk("cfg2_77", {56'd0, cfg_q[23:16]}, 64'h77);
      stat_evt = 32'h0000_0100;
      rd(16'h0541, 8'h00, "stat1_before");
      stat_evt = '0;
      rst = 1'b1;
      rd(16'h0582, 8'h00, "rd_in_reset");
      rst = 1'b0;
      chk("post_rst_cfg2", {56'd0, cfg_q[23:16]}, 64'h33);
      chk("post_rst_locked", {63'd0, cfg_locked}, 64'd1);
      chk("post_rst_wstb", {56'd0, cfg_wstb}, 64'd0);
      rd(16'h0541, 8'h00, "post_rst_stat1");
      rd(16'h05FE, 8'h00, "post_rst_errcnt");
      rd(16'h0580, 8'h11, "post_rst_cfg0");

      tick();
      tick();
      chk("sb_empty", 64'(sb_exp.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
